// File: rtl/clock_divider.sv
// Four-channel 50% duty clock divider: each output toggles every DIV/2 enabled clk edges.
// Channels share en, sync and rst so that all outputs are phase-aligned after sync or reset.
`timescale 1ns/1ps

module clock_divider_channel #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync,
    output logic clk_out
);

    localparam int HALF = DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] TERM = CW'(HALF - 1);

    if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
        $error("clock_divider_channel: DIV must be even and >= 2");
    end

    logic [CW-1:0] cnt;

    // Priority: rst, then sync, then en. sync discards any partial half-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (sync) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (en) begin
            if (cnt == TERM) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

module clock_divider #(
    parameter int DIV_VGA  = 2,
    parameter int DIV_UART = 5208,
    parameter int DIV_LM   = 50000,
    parameter int DIV_DB   = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync,
    output logic clk_VGA,
    output logic clk_UART,
    output logic clk_LM,
    output logic clk_DB
);

    clock_divider_channel #(.DIV(DIV_VGA)) u_vga (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .clk_out (clk_VGA)
    );

    clock_divider_channel #(.DIV(DIV_UART)) u_uart (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .clk_out (clk_UART)
    );

    clock_divider_channel #(.DIV(DIV_LM)) u_lm (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .clk_out (clk_LM)
    );

    clock_divider_channel #(.DIV(DIV_DB)) u_db (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .clk_out (clk_DB)
    );

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider with DIV = 2/4/6/8: an enabled-edge counter predicts each output.
`timescale 1ns/1ps

module tb_clock_divider;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sync;
    logic clk_VGA, clk_UART, clk_LM, clk_DB;

    always #5 clk = ~clk;

    clock_divider #(
        .DIV_VGA  (2),
        .DIV_UART (4),
        .DIV_LM   (6),
        .DIV_DB   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .clk_VGA  (clk_VGA),
        .clk_UART (clk_UART),
        .clk_LM   (clk_LM),
        .clk_DB   (clk_DB)
    );

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_edges  = 0;   // enabled edges since last rst/sync

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output n of a channel with half-period h is high in the odd half-periods.
    function automatic logic [3:0] model_out(input int n);
        model_out = {1'(((n / 4) % 2) != 0), 1'(((n / 3) % 2) != 0),
                     1'(((n / 2) % 2) != 0), 1'((n % 2) != 0)};
    endfunction

    function automatic logic [3:0] dut_out();
        dut_out = {clk_DB, clk_LM, clk_UART, clk_VGA};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic e, input logic s, input logic r, input string tag);
        logic [3:0] got;
        logic [3:0] want;
        @(negedge clk);
        en = e; sync = s; rst = r;
        @(posedge clk);
        if (r || s) n_edges = 0;
        else if (e) n_edges++;
        exp_q.push_back(model_out(n_edges));
        #1;
        got  = dut_out();
        want = exp_q.pop_front();
        check_eq(tag, 32'(got), 32'(want));
    endtask

    int hi_cnt[4];
    int tol;
    int found;

    initial begin
        rst = 1'b1; en = 1'b0; sync = 1'b0;
        #3;
        check_eq("reset_outputs", 32'(dut_out()), 32'h0);
        step(1'b1, 1'b0, 1'b1, "reset_held");
        step(1'b1, 1'b0, 1'b1, "reset_held");

        // Release with en=1: VGA every edge, UART@2, LM@3, DB@4.
        step(1'b1, 1'b0, 1'b0, "release_e1");
        check_eq("vga_first_rise", 32'(clk_VGA), 32'h1);
        step(1'b1, 1'b0, 1'b0, "release_e2");
        check_eq("uart_first_rise", 32'(clk_UART), 32'h1);
        step(1'b1, 1'b0, 1'b0, "release_e3");
        check_eq("lm_first_rise", 32'(clk_LM), 32'h1);
        step(1'b1, 1'b0, 1'b0, "release_e4");
        check_eq("db_first_rise", 32'(clk_DB), 32'h1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, "free_run");

        // Run 10, freeze 5, resume.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, "pre_freeze");
        for (int i = 0; i < 5; i++)  step(1'b0, 1'b0, 1'b0, "frozen");
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 1'b0, "resume");

        // Sync pulses at random phases, with en=1 (sync wins) and en=0.
        for (int k = 0; k < 4; k++) begin
            int pre;
            pre = $urandom_range(1, 7);
            for (int i = 0; i < pre; i++) step(1'b1, 1'b0, 1'b0, "pre_sync");
            step(1'b1, 1'b1, 1'b0, "sync_en_hi");
            check_eq("sync_clears", 32'(dut_out()), 32'h0);
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, "post_sync");
        end
        step(1'b0, 1'b1, 1'b0, "sync_en_lo");
        check_eq("sync_clears_en0", 32'(dut_out()), 32'h0);
        step(1'b1, 1'b0, 1'b0, "post_sync_en0");
        step(1'b1, 1'b0, 1'b0, "post_sync_en0");
        check_eq("aligned_uart", 32'(clk_UART), 32'h1);

        // Asynchronous reset while clk_DB is high.
        found = 0;
        for (int i = 0; i < 16 && found == 0; i++) begin
            step(1'b1, 1'b0, 1'b0, "seek_db_high");
            if (clk_DB) found = 1;
        end
        check_eq("db_high_found", 32'(found), 32'h1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("db_async_fall", 32'(clk_DB), 32'h0);
        check_eq("async_all_zero", 32'(dut_out()), 32'h0);
        n_edges = 0;
        step(1'b1, 1'b0, 1'b1, "rst_held_mid");
        step(1'b1, 1'b0, 1'b0, "rerelease_e1");
        step(1'b1, 1'b0, 1'b0, "rerelease_e2");
        step(1'b1, 1'b0, 1'b0, "rerelease_e3");
        step(1'b1, 1'b0, 1'b0, "rerelease_e4");
        check_eq("db_rise_after_rst", 32'(clk_DB), 32'h1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, "rerelease_run");

        // 1000 enabled cycles from a fresh sync: duty check.
        step(1'b1, 1'b1, 1'b0, "duty_sync");
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 1'b0, "duty_run");
            if (clk_VGA)  hi_cnt[0]++;
            if (clk_UART) hi_cnt[1]++;
            if (clk_LM)   hi_cnt[2]++;
            if (clk_DB)   hi_cnt[3]++;
        end
        for (int c = 0; c < 4; c++) begin
            int div;
            int want;
            div  = 2 * (c + 1);
            want = (1000 / div) * (div / 2);
            tol  = div / 2;
            check_eq("duty_high_count_in_tol",
                     32'((hi_cnt[c] >= want - tol) && (hi_cnt[c] <= want + tol)), 32'h1);
        end

        check_eq("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
